adbg_or1k_burst_ctrl: RTL and testbench
=======================================

Name: adbg_or1k_burst_ctrl

Overview:
- TCK-domain burst sequencer that sits directly upstream of the OR1K debug BIU.
- Accepts one burst command (start SPR address, word count, direction) and breaks it into single-word strobe/ready transactions on the BIU debug-side port.
- Streams write data in and read data out through valid/ready handshakes, so the JTAG shift logic never handles BIU timing.

Parameters:
- CNT_W, 16, width of word count and words-done counter
- ADDR_INC, 1, address increment per word (SPR space is word-addressed)

Ports:
- tck_i  in  1  clock (debug TCK domain)
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  controller idle, can accept a command
- cmd_addr_i  in  32  start address
- cmd_count_i  in  CNT_W  number of words
- cmd_write_i  in  1  1 = write burst, 0 = read burst
- abort_i  in  1  terminate current burst
- wdata_i  in  32  write data word
- wdata_valid_i  in  1  write word valid
- wdata_ready_o  out  1  write word accepted
- rdata_o  out  32  read data word
- rdata_valid_o  out  1  read word valid
- rdata_ready_i  in  1  read word consumed
- biu_addr_o  out  32  to BIU addr_i
- biu_data_o  out  32  to BIU data_i
- biu_rd_wrn_o  out  1  to BIU rd_wrn_i
- biu_strobe_o  out  1  to BIU strobe_i
- biu_data_i  in  32  from BIU data_o
- biu_rdy_i  in  1  from BIU rdy_o
- busy_o  out  1  burst in progress
- words_done_o  out  CNT_W  words completed in current or last burst

Behaviour:
- Clock and reset: one clock, tck_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - state IDLE; cmd_ready_o=1; busy_o=0
  - wdata_ready_o=0; rdata_valid_o=0; rdata_o=0
  - biu_addr_o=0; biu_data_o=0; biu_rd_wrn_o=1; biu_strobe_o=0
  - words_done_o=0
- States:
  - IDLE:
    - cmd_ready_o=1.
    - On cmd_valid_i: latch addr/count/dir and clear words_done.
    - If count=0, stay IDLE with no BIU access.
    - Otherwise go to FETCH if writing, ISSUE if reading.
  - FETCH (write only):
    - wdata_ready_o=1 combinationally.
    - On wdata_valid_i: capture wdata_i into biu_data_o, go to ISSUE.
  - ISSUE:
    - biu_strobe_o = biu_rdy_i (combinational, single cycle); biu_rd_wrn_o = ~dir.
    - On the edge with strobe high, go to WAIT.
    - While biu_rdy_i=0, hold the strobe low and stay.
  - WAIT:
    - BIU drops rdy the cycle after the strobe, so any biu_rdy_i=1 seen in WAIT means the word is complete.
    - On completion: words_done+1, address += ADDR_INC.
    - Read: capture biu_data_i into rdata_o, go to PUSH.
    - Write: go to FETCH if words remain, else IDLE.
  - PUSH (read only):
    - rdata_valid_o=1; rdata_o stable.
    - On rdata_ready_i: go to ISSUE if words remain, else IDLE.
- biu_addr_o, biu_data_o and biu_rd_wrn_o are registered and held stable from ISSUE through the end of WAIT.
- busy_o = (state != IDLE).
- Latency: strobe is issued on the first cycle in ISSUE with biu_rdy_i=1. Minimum per read word is ISSUE(1) + WAIT(BIU) + PUSH(1).
- Address wraps modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
- words_done_o saturates at the count; it is held after the burst until the next command is accepted.
- abort_i:
  - In FETCH, ISSUE (before strobe) or PUSH: go to IDLE next cycle. A pending rdata word is dropped; wdata is not consumed.
  - In WAIT: the in-flight BIU access cannot be cancelled. Wait for biu_rdy_i, count the word, discard read data, then IDLE.
  - In the same cycle as a strobe: the strobe still goes out; treat as the WAIT case.
  - In IDLE: ignored. cmd_valid_i and abort_i in the same cycle means the command is not accepted.
- cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).
- Reset mid-burst: all state clears immediately. A BIU transaction may still be outstanding; the BIU resets on the same rst_i.

Test Plan:
- Read burst, addr=0x2800, count=3; BIU model returns 0xA0, 0xA1, 0xA2 with rdy low 4 cycles each; rdata_ready_i=1 → strobes at addr 0x2800/0x2801/0x2802 with rd_wrn=1, rdata sequence 0xA0/0xA1/0xA2, words_done=3, cmd_ready_o back to 1.
- Write burst, addr=0x3000, count=2, data 0xDEADBEEF then 0x12345678, wdata_valid delayed 5 cycles before word 2 → exactly two strobes, rd_wrn=0, biu_data_o matches each word, no strobe while waiting in FETCH.
- count=0 command → no strobe, busy_o never asserts, words_done_o=0.
- Read burst with rdata_ready_i held low 10 cycles on word 1 → rdata_valid_o and rdata_o stay stable, no new strobe until ready.
- abort_i pulsed while in WAIT on word 2 of a 4-word write → BIU completion awaited, words_done=2, IDLE, no further strobes; abort in PUSH → IDLE next cycle.
- Address wrap: read at 0xFFFFFFFF, count=2 → second strobe address 0x00000000.

Source files
------------

// File: rtl/adbg_or1k_burst_ctrl.sv
// rtl/adbg_or1k_burst_ctrl.sv - TCK-domain burst sequencer in front of the OR1K debug BIU.
// Splits one burst command into single-word strobe/rdy accesses with streamed data.
module adbg_or1k_burst_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ADDR_INC = 1
) (
  input  logic             tck_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             cmd_write_i,
  input  logic             abort_i,
  input  logic [31:0]      wdata_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  input  logic             rdata_ready_i,
  output logic [31:0]      biu_addr_o,
  output logic [31:0]      biu_data_o,
  output logic             biu_rd_wrn_o,
  output logic             biu_strobe_o,
  input  logic [31:0]      biu_data_i,
  input  logic             biu_rdy_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_done_o
);

  localparam logic [31:0] ADDR_STEP = 32'(ADDR_INC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_PUSH
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             rd_wrn_q, rd_wrn_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] done_inc;

  // Saturating so words_done never exceeds the commanded count.
  assign done_inc = (done_q < count_q) ? done_q + 1'b1 : done_q;

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      rd_wrn_q <= 1'b1;
      abort_q  <= 1'b0;
      count_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      rd_wrn_q <= rd_wrn_d;
      abort_q  <= abort_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdat_d        = wdat_q;
    rdat_d        = rdat_q;
    rd_wrn_d      = rd_wrn_q;
    abort_d       = abort_q;
    count_d       = count_q;
    done_d        = done_q;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    biu_strobe_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        abort_d     = 1'b0;
        if (cmd_valid_i && !abort_i) begin
          addr_d   = cmd_addr_i;
          count_d  = cmd_count_i;
          rd_wrn_d = ~cmd_write_i;
          done_d   = '0;
          if (cmd_count_i != '0) begin
            state_d = cmd_write_i ? S_FETCH : S_ISSUE;
          end
        end
      end

      S_FETCH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          wdata_ready_o = 1'b1;
          if (wdata_valid_i) begin
            wdat_d  = wdata_i;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        biu_strobe_o = biu_rdy_i;
        if (biu_rdy_i) begin
          // An abort alongside the strobe cannot stop the access; finish it first.
          abort_d = abort_i;
          state_d = S_WAIT;
        end else if (abort_i) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (abort_i) abort_d = 1'b1;
        if (biu_rdy_i) begin
          done_d = done_inc;
          addr_d = addr_q + ADDR_STEP;
          if (abort_q || abort_i) begin
            state_d = S_IDLE;
          end else if (rd_wrn_q) begin
            rdat_d  = biu_data_i;
            state_d = S_PUSH;
          end else begin
            state_d = (done_inc < count_q) ? S_FETCH : S_IDLE;
          end
        end
      end

      S_PUSH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (rdata_ready_i) begin
          state_d = (done_q < count_q) ? S_ISSUE : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_o       = rdat_q;
  assign rdata_valid_o = (state_q == S_PUSH);
  assign biu_addr_o    = addr_q;
  assign biu_data_o    = wdat_q;
  assign biu_rd_wrn_o  = rd_wrn_q;
  assign busy_o        = (state_q != S_IDLE);
  assign words_done_o  = done_q;

endmodule

// File: tb/tb_adbg_or1k_burst_ctrl.sv
// tb/tb_adbg_or1k_burst_ctrl.sv - self-checking bench for adbg_or1k_burst_ctrl.
// Transaction-level reference: expected strobe addresses, data and read stream per burst.
module tb_adbg_or1k_burst_ctrl;
  localparam int CNT_W = 16;

  logic             tck = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [31:0]      cmd_addr_i;
  logic [CNT_W-1:0] cmd_count_i;
  logic             cmd_write_i;
  logic             abort_i;
  logic [31:0]      wdata_i;
  logic             wdata_valid_i;
  logic             wdata_ready_o;
  logic [31:0]      rdata_o;
  logic             rdata_valid_o;
  logic             rdata_ready_i;
  logic [31:0]      biu_addr_o;
  logic [31:0]      biu_data_o;
  logic             biu_rd_wrn_o;
  logic             biu_strobe_o;
  logic [31:0]      biu_data_i;
  logic             biu_rdy_i;
  logic             busy_o;
  logic [CNT_W-1:0] words_done_o;

  adbg_or1k_burst_ctrl #(.CNT_W(CNT_W), .ADDR_INC(1)) dut (
    .tck_i(tck), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_count_i(cmd_count_i), .cmd_write_i(cmd_write_i), .abort_i(abort_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .biu_addr_o(biu_addr_o), .biu_data_o(biu_data_o), .biu_rd_wrn_o(biu_rd_wrn_o),
    .biu_strobe_o(biu_strobe_o), .biu_data_i(biu_data_i), .biu_rdy_i(biu_rdy_i),
    .busy_o(busy_o), .words_done_o(words_done_o)
  );

  always #5 tck = ~tck;

  int errors = 0;
  int checks = 0;

  // BIU model: rdy drops for 'lat' cycles after each strobe, then returns with data.
  int          bcnt = 0;
  logic [31:0] baddr = '0;

  typedef struct {
    logic [31:0] a;
    int          cnt;
    bit          wr;
    int          lat;
    int          gap;
    logic [31:0] w0;
    logic [31:0] w1;
    int          amode;
    int          ak;
    int          exp_strobes;
    int          exp_done;
    logic [31:0] exp_last;
    int          exp_reads;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return 32'hA0 + (a - 32'h2800);
  endfunction

  task automatic idle_inputs();
    cmd_valid_i   = 1'b0;
    abort_i       = 1'b0;
    wdata_valid_i = 1'b0;
    rdata_ready_i = 1'b0;
    biu_rdy_i     = (bcnt == 0);
  endtask

  task automatic run_burst(input vec_t v, output int ns, output int nr, output logic [31:0] last,
                           output int acyc, output int ecyc, output bit busy_seen);
    logic [31:0] wd[$];
    logic [31:0] prev_r;
    int wi, ri, wwait, rwait, cyc;
    bit aborted, hold;
    for (int i = 0; i < v.cnt; i++) wd.push_back(i == 0 ? v.w0 : (i == 1 ? v.w1 : $urandom()));
    ns = 0; nr = 0; last = '0; acyc = -1; busy_seen = 0;
    wi = 0; ri = 0; wwait = v.gap; rwait = v.gap; aborted = 0; hold = 0; prev_r = '0;

    @(negedge tck);
    idle_inputs();
    cmd_valid_i = 1'b1;
    cmd_addr_i  = v.a;
    cmd_count_i = CNT_W'(v.cnt);
    cmd_write_i = v.wr;
    #1 chk("cmd_ready_idle", cmd_ready_o, 1);

    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge tck);
      if (cyc == 0) chk("words_done_clear", words_done_o, 0);
      if (busy_o) busy_seen = 1;
      if (cmd_ready_o) break;
      if (hold) begin
        chk("rdata_valid_held", rdata_valid_o, 1);
        chk("rdata_stable", rdata_o, prev_r);
      end
      // Commands while busy must be ignored.
      cmd_valid_i = 1'($urandom_range(0, 1));
      cmd_addr_i  = $urandom();
      cmd_count_i = CNT_W'($urandom_range(1, 9));
      cmd_write_i = 1'($urandom_range(0, 1));
      abort_i = 1'b0;
      if (v.amode == 1 && !aborted && bcnt > 0 && ns == v.ak + 1) begin
        abort_i = 1'b1; aborted = 1;
      end
      if (v.amode == 2 && !aborted && rdata_valid_o && ri == v.ak) begin
        abort_i = 1'b1; aborted = 1; acyc = cyc;
      end
      wdata_valid_i = (wwait == 0) && (wi < wd.size());
      wdata_i       = wdata_valid_i ? wd[wi] : $urandom();
      rdata_ready_i = rdata_valid_o && (rwait == 0) && !abort_i;
      if (rdata_valid_o && rwait > 0) rwait--;
      biu_rdy_i  = (bcnt == 0);
      biu_data_i = rd_fn(baddr);
      #1;
      chk("busy_vs_cmd_ready", busy_o, !cmd_ready_o);
      if (biu_strobe_o) begin
        chk("strobe_exclusive", wdata_ready_o | rdata_valid_o, 0);
        if (ns < v.cnt) begin
          chk("strobe_addr", biu_addr_o, v.a + 32'(ns));
          chk("strobe_rd_wrn", biu_rd_wrn_o, !v.wr);
          if (v.wr) chk("strobe_wdata", biu_data_o, wd[ns]);
        end
        last = biu_addr_o; baddr = biu_addr_o; bcnt = v.lat; ns++;
      end else if (bcnt > 0) begin
        bcnt--;
      end
      if (wdata_valid_i && wdata_ready_o) begin
        wi++; wwait = v.gap;
      end else if (wdata_ready_o && wwait > 0) begin
        wwait--;
      end
      if (rdata_ready_i && rdata_valid_o) begin
        chk("rdata_value", rdata_o, rd_fn(v.a + 32'(ri)));
        ri++; rwait = v.gap; hold = 0;
      end else begin
        hold = rdata_valid_o && !abort_i;
        prev_r = rdata_o;
      end
    end
    idle_inputs();
    chk("burst_finished", cmd_ready_o, 1);
    nr = ri; ecyc = cyc;
  endtask

  task automatic check_burst(input vec_t v, input string tag);
    int ns, nr, acyc, ecyc;
    logic [31:0] last;
    bit bs;
    run_burst(v, ns, nr, last, acyc, ecyc, bs);
    chk({tag, "_strobes"}, ns, v.exp_strobes);
    chk({tag, "_words_done"}, words_done_o, v.exp_done);
    chk({tag, "_last_addr"}, last, v.exp_last);
    chk({tag, "_reads"}, nr, v.exp_reads);
    chk({tag, "_busy_seen"}, bs, v.exp_strobes > 0);
    chk({tag, "_busy_after"}, busy_o, 0);
    if (v.amode == 2) chk({tag, "_abort_latency"}, ecyc - acyc, 1);
  endtask

  initial begin
    vec_t v;
    rst_i = 1'b1;
    cmd_addr_i = '0; cmd_count_i = '0; cmd_write_i = 1'b0; wdata_i = '0; biu_data_i = '0;
    idle_inputs();
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_wdata_ready", wdata_ready_o, 0);
    chk("rst_rdata_valid", rdata_valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_biu_addr", biu_addr_o, 0);
    chk("rst_biu_data", biu_data_o, 0);
    chk("rst_rd_wrn", biu_rd_wrn_o, 1);
    chk("rst_strobe", biu_strobe_o, 0);
    chk("rst_words_done", words_done_o, 0);
    @(negedge tck); @(negedge tck);
    rst_i = 1'b0;

    //          addr           cnt wr lat gap w0            w1           am ak str done last          rd
    tbl[0] = '{32'h0000_2800, 3, 0, 4, 0,  32'h0,        32'h0,        0, 0, 3, 3, 32'h0000_2802, 3};
    tbl[1] = '{32'h0000_3000, 2, 1, 2, 5,  32'hDEADBEEF, 32'h12345678, 0, 0, 2, 2, 32'h0000_3001, 0};
    tbl[2] = '{32'h0000_1234, 0, 0, 1, 0,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0000_0000, 0};
    tbl[3] = '{32'h0000_2810, 2, 0, 1, 10, 32'h0,        32'h0,        0, 0, 2, 2, 32'h0000_2811, 2};
    tbl[4] = '{32'h0000_4000, 4, 1, 3, 0,  32'h11111111, 32'h22222222, 1, 1, 2, 2, 32'h0000_4001, 0};
    tbl[5] = '{32'h0000_2820, 3, 0, 2, 0,  32'h0,        32'h0,        2, 0, 1, 1, 32'h0000_2820, 0};
    tbl[6] = '{32'hFFFF_FFFF, 2, 0, 1, 1,  32'h0,        32'h0,        0, 0, 2, 2, 32'h0000_0000, 2};
    for (int i = 0; i < 7; i++) check_burst(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v.a     = (i % 4 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom();
      v.cnt   = $urandom_range(1, 6);
      v.wr    = 1'($urandom_range(0, 1));
      v.lat   = $urandom_range(1, 4);
      v.gap   = $urandom_range(0, 3);
      v.w0    = $urandom();
      v.w1    = $urandom();
      v.amode = 0;
      v.ak    = 0;
      v.exp_strobes = v.cnt;
      v.exp_done    = v.cnt;
      v.exp_last    = v.a + 32'(v.cnt - 1);
      v.exp_reads   = v.wr ? 0 : v.cnt;
      check_burst(v, $sformatf("rnd%0d", i));
    end

    // Command together with abort in IDLE is refused.
    @(negedge tck);
    idle_inputs();
    cmd_valid_i = 1'b1; abort_i = 1'b1; cmd_addr_i = 32'h2800; cmd_count_i = 3; cmd_write_i = 1'b0;
    @(negedge tck);
    chk("cmd_with_abort_busy", busy_o, 0);
    idle_inputs();

    // Asynchronous reset in the middle of a read burst.
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h2800; cmd_count_i = 5; cmd_write_i = 1'b0; biu_rdy_i = 1'b1;
    @(negedge tck);
    cmd_valid_i = 1'b0;
    @(negedge tck);
    biu_rdy_i = 1'b0;
    chk("mid_busy_before_rst", busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cmd_ready", cmd_ready_o, 1);
    chk("mid_rst_words_done", words_done_o, 0);
    chk("mid_rst_biu_addr", biu_addr_o, 0);
    chk("mid_rst_strobe", biu_strobe_o, 0);
    @(negedge tck);
    rst_i = 1'b0; bcnt = 0;
    idle_inputs();
    @(negedge tck);
    chk("post_rst_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
